mod_counter: RTL and testbench

- Parametrised successor to the free-running 4-bit counter.
- Configurable width and modulus; up/down direction; synchronous clear and parallel load; count enable; wrap or saturate mode; terminal-count and event flags.
- Used as a generic timebase and event counter inside the Counter block family. Drives timers, baud/tick generators and loop counters.

---
 rtl/counter_pkg.sv | 31 +++
 rtl/mod_counter_prescaler.sv | 48 ++++
 rtl/mod_counter.sv | 151 +++++++++++++++
 tb/tb_mod_counter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// -----------------------------------------------------------------------------
// counter_pkg
// Shared types and helpers for the mod_counter family.
//   cnt_mode_e : wrap or saturate behaviour at the range limits
//   cnt_dir_e  : count direction, encoded to match the up_dn input
//   clamp_load : limits a parallel-load value to the legal count range
// -----------------------------------------------------------------------------
package counter_pkg;

  typedef enum logic {
    CNT_WRAP = 1'b0,
    CNT_SAT  = 1'b1
  } cnt_mode_e;

  typedef enum logic {
    CNT_DOWN = 1'b0,
    CNT_UP   = 1'b1
  } cnt_dir_e;

  // Operands are 33 bits so any counter width up to 32 fits without truncation.
  function automatic logic [32:0] clamp_load(input logic [32:0] val, input logic [32:0] max);
    logic [32:0] res;
    if (val > max) begin
      res = max;
    end else begin
      res = val;
    end
    return res;
  endfunction

endpackage

// File: rtl/mod_counter_prescaler.sv
// -----------------------------------------------------------------------------
// mod_counter_prescaler
// Divides enabled cycles by PRESCALE. Used by mod_counter only when
// MOD_COUNTER_PRESCALE_EN is defined.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   clr   : synchronous restart of the prescale phase
//   en    : advance the prescale counter this cycle
//   step  : high on the enabled cycle that completes a PRESCALE period
// -----------------------------------------------------------------------------
module mod_counter_prescaler #(
  parameter int unsigned PRESCALE = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic step
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] r_pre;
  logic          w_last;

  assign w_last = (r_pre == LAST);
  assign step   = en & w_last;

  // Prescale phase counter: restarts on clr, wraps to 0 after LAST.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre <= '0;
    end else if (clr) begin
      r_pre <= '0;
    end else if (en) begin
      if (w_last) begin
        r_pre <= '0;
      end else begin
        r_pre <= r_pre + PW'(1);
      end
    end else begin
      r_pre <= r_pre;
    end
  end

endmodule

// File: rtl/mod_counter.sv
// -----------------------------------------------------------------------------
// mod_counter
// Parametrised up/down modulo counter with clear, load, enable, wrap or
// saturate at the limits, terminal-count and wrap/overflow flags.
// Optional macro MOD_COUNTER_PRESCALE_EN adds parameter PRESCALE and an
// enable prescaler; when undefined every enabled cycle steps the counter.
// Ports:
//   clk, rst_n  : clock (rising edge), asynchronous active-low reset
//   clr         : synchronous clear (highest priority)
//   load        : synchronous parallel load of load_val (clamped to MAX_VAL)
//   load_val    : load value
//   en, up_dn   : count enable, direction (1 = up)
//   count       : registered count
//   tc          : combinational terminal count (next step hits a limit)
//   wrap_pulse  : registered one-cycle pulse on wrap / saturation attempt
//   ovf_sticky  : sticky wrap/saturation flag, cleared by clr or reset
// -----------------------------------------------------------------------------
module mod_counter
  import counter_pkg::*;
#(
  parameter int unsigned      WIDTH    = 4,
  parameter longint unsigned  MAX_VAL  = (64'd1 << WIDTH) - 64'd1,
  parameter int unsigned      SATURATE = 0
`ifdef MOD_COUNTER_PRESCALE_EN
  ,
  parameter int unsigned      PRESCALE = 4
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up_dn,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap_pulse,
  output logic             ovf_sticky
);

  localparam cnt_mode_e       MODE    = (SATURATE != 0) ? CNT_SAT : CNT_WRAP;
  localparam logic [WIDTH:0]  MAX_EXT = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH-1:0] MAX_W  = WIDTH'(MAX_VAL);

  logic [WIDTH-1:0] r_count;
  logic             r_wrap;
  logic             r_ovf;

  logic [WIDTH-1:0] w_count_nxt;
  logic             w_wrap_nxt;
  logic             w_ovf_nxt;
  logic [WIDTH:0]   w_inc;
  logic [WIDTH:0]   w_dec;
  logic             w_up_lim;
  logic             w_dn_lim;
  logic [WIDTH-1:0] w_load_clamped;
  logic             w_step;
  logic             w_tc_base;
  cnt_dir_e         w_dir;

  // Extended arithmetic: the extra bit exposes overflow past MAX_VAL and
  // borrow below 0 so the limit checks come straight from the sums.
  assign w_inc    = {1'b0, r_count} + (WIDTH+1)'(1);
  assign w_dec    = {1'b0, r_count} - (WIDTH+1)'(1);
  assign w_up_lim = (w_inc > MAX_EXT);
  assign w_dn_lim = w_dec[WIDTH];
  assign w_dir    = cnt_dir_e'(up_dn);

  assign w_load_clamped = WIDTH'(clamp_load(33'(load_val), 33'(MAX_VAL)));

  assign w_tc_base = en & ((up_dn & w_up_lim) | (~up_dn & w_dn_lim));

`ifdef MOD_COUNTER_PRESCALE_EN
  // Load restarts the prescale phase just like clr does.
  logic w_pre_clr;
  assign w_pre_clr = clr | load;

  mod_counter_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_pre_clr),
    .en    (en),
    .step  (w_step)
  );

  assign tc = w_tc_base & w_step;
`else
  assign w_step = en;
  assign tc     = w_tc_base;
`endif

  // Next-state selection with priority clr > load > step.
  always_comb begin
    w_count_nxt = r_count;
    w_wrap_nxt  = 1'b0;
    w_ovf_nxt   = r_ovf;
    if (clr) begin
      w_count_nxt = '0;
      w_ovf_nxt   = 1'b0;
    end else if (load) begin
      w_count_nxt = w_load_clamped;
    end else if (w_step) begin
      case (w_dir)
        CNT_UP: begin
          if (w_up_lim) begin
            w_wrap_nxt  = 1'b1;
            w_ovf_nxt   = 1'b1;
            w_count_nxt = (MODE == CNT_SAT) ? r_count : '0;
          end else begin
            w_count_nxt = w_inc[WIDTH-1:0];
          end
        end
        CNT_DOWN: begin
          if (w_dn_lim) begin
            w_wrap_nxt  = 1'b1;
            w_ovf_nxt   = 1'b1;
            w_count_nxt = (MODE == CNT_SAT) ? r_count : MAX_W;
          end else begin
            w_count_nxt = w_dec[WIDTH-1:0];
          end
        end
        default: begin
          w_count_nxt = r_count;
        end
      endcase
    end else begin
      w_count_nxt = r_count;
    end
  end

  // Count and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_wrap  <= w_wrap_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

  assign count      = r_count;
  assign wrap_pulse = r_wrap;
  assign ovf_sticky = r_ovf;

endmodule

// File: tb/tb_mod_counter.sv
// -----------------------------------------------------------------------------
// tb_mod_counter
// Directed bench for mod_counter with WIDTH=4, MAX_VAL=9: one wrapping
// instance, one saturating instance and, when MOD_COUNTER_PRESCALE_EN is
// defined, a wrapping instance with PRESCALE=3.
// -----------------------------------------------------------------------------
module tb_mod_counter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  // Wrapping instance
  logic       w_clr = 1'b0, w_load = 1'b0, w_en = 1'b0, w_up = 1'b1;
  logic [3:0] w_lval = 4'd0;
  logic [3:0] w_cnt;
  logic       w_tc, w_wp, w_ovf;

  mod_counter #(.WIDTH(4), .MAX_VAL(64'd9), .SATURATE(0)
`ifdef MOD_COUNTER_PRESCALE_EN
    , .PRESCALE(1)
`endif
  ) u_wrap (
    .clk(clk), .rst_n(rst_n), .clr(w_clr), .load(w_load), .load_val(w_lval),
    .en(w_en), .up_dn(w_up), .count(w_cnt), .tc(w_tc), .wrap_pulse(w_wp),
    .ovf_sticky(w_ovf)
  );

  // Saturating instance
  logic       s_clr = 1'b0, s_load = 1'b0, s_en = 1'b0, s_up = 1'b1;
  logic [3:0] s_lval = 4'd0;
  logic [3:0] s_cnt;
  logic       s_tc, s_wp, s_ovf;

  mod_counter #(.WIDTH(4), .MAX_VAL(64'd9), .SATURATE(1)
`ifdef MOD_COUNTER_PRESCALE_EN
    , .PRESCALE(1)
`endif
  ) u_sat (
    .clk(clk), .rst_n(rst_n), .clr(s_clr), .load(s_load), .load_val(s_lval),
    .en(s_en), .up_dn(s_up), .count(s_cnt), .tc(s_tc), .wrap_pulse(s_wp),
    .ovf_sticky(s_ovf)
  );

`ifdef MOD_COUNTER_PRESCALE_EN
  logic       p_clr = 1'b0, p_load = 1'b0, p_en = 1'b0, p_up = 1'b1;
  logic [3:0] p_lval = 4'd0;
  logic [3:0] p_cnt;
  logic       p_tc, p_wp, p_ovf;

  mod_counter #(.WIDTH(4), .MAX_VAL(64'd9), .SATURATE(0), .PRESCALE(3)) u_pre (
    .clk(clk), .rst_n(rst_n), .clr(p_clr), .load(p_load), .load_val(p_lval),
    .en(p_en), .up_dn(p_up), .count(p_cnt), .tc(p_tc), .wrap_pulse(p_wp),
    .ovf_sticky(p_ovf)
  );
`endif

  int n_asserts = 0;
  int n_fail    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          exp_dn [9];
    int          prev;
    int          exp_sat [4];
    logic        exp_swp [4];

    // ---------------- reset ----------------
    repeat (3) @(posedge clk);
    #1;
    chk("rst_count", 32'(w_cnt), 32'd0);
    chk("rst_wrap",  32'(w_wp),  32'd0);
    chk("rst_ovf",   32'(w_ovf), 32'd0);
    rst_n = 1'b1;
    tick();

    // ---------------- count up 12 cycles: 0..9,0,1 ----------------
    w_en = 1'b1; w_up = 1'b1;
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("up_count_%0d", i), 32'(w_cnt), 32'(i % 10));
      chk($sformatf("up_tc_%0d", i),    32'(w_tc),  32'((i % 10) == 9));
      chk($sformatf("up_wrap_%0d", i),  32'(w_wp),  32'(i == 10));
      if (i < 11) tick();
    end
    chk("up_ovf", 32'(w_ovf), 32'd1);

    // ---------------- load 7 then count down 9 cycles ----------------
    w_en = 1'b0; w_load = 1'b1; w_lval = 4'd7;
    tick();
    chk("load7_count", 32'(w_cnt), 32'd7);
    chk("load7_ovf",   32'(w_ovf), 32'd1);
    w_load = 1'b0; w_en = 1'b1; w_up = 1'b0;
    exp_dn = '{6, 5, 4, 3, 2, 1, 0, 9, 8};
    prev = 7;
    for (int k = 0; k < 9; k++) begin
      chk($sformatf("dn_tc_%0d", k), 32'(w_tc), 32'(prev == 0));
      tick();
      chk($sformatf("dn_count_%0d", k), 32'(w_cnt), 32'(exp_dn[k]));
      chk($sformatf("dn_wrap_%0d", k),  32'(w_wp),  32'(k == 7));
      prev = exp_dn[k];
    end

    // ---------------- clamped load ----------------
    w_en = 1'b0; w_load = 1'b1; w_lval = 4'd15;
    tick();
    chk("load15_clamp", 32'(w_cnt), 32'd9);
    chk("load15_wrap",  32'(w_wp),  32'd0);
    chk("en0_tc",       32'(w_tc),  32'd0);

    // ---------------- async reset mid-cycle at count 6 ----------------
    w_lval = 4'd6;
    tick();
    w_load = 1'b0;
    chk("pre_rst_count", 32'(w_cnt), 32'd6);
    chk("pre_rst_ovf",   32'(w_ovf), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_count", 32'(w_cnt), 32'd0);
    chk("async_rst_ovf",   32'(w_ovf), 32'd0);
    chk("async_rst_wrap",  32'(w_wp),  32'd0);
    #2 rst_n = 1'b1;
    tick();

    // ---------------- clr beats load; load beats en ----------------
    w_en = 1'b1; w_up = 1'b0;
    tick();
    chk("dn_wrap0_count", 32'(w_cnt), 32'd9);
    chk("dn_wrap0_ovf",   32'(w_ovf), 32'd1);
    w_en = 1'b0; w_clr = 1'b1; w_load = 1'b1; w_lval = 4'd5;
    tick();
    chk("clr_load_count", 32'(w_cnt), 32'd0);
    chk("clr_load_ovf",   32'(w_ovf), 32'd0);
    chk("clr_load_wrap",  32'(w_wp),  32'd0);
    w_clr = 1'b0; w_en = 1'b1; w_up = 1'b1;
    tick();
    chk("load_en_count", 32'(w_cnt), 32'd5);
    w_load = 1'b0;
    tick();
    chk("after_load_up", 32'(w_cnt), 32'd6);
    w_en = 1'b0;

    // ---------------- saturating: up from 8 ----------------
    s_load = 1'b1; s_lval = 4'd8;
    tick();
    chk("sat_load8", 32'(s_cnt), 32'd8);
    s_load = 1'b0; s_en = 1'b1; s_up = 1'b1;
    exp_sat = '{9, 9, 9, 9};
    exp_swp = '{1'b0, 1'b1, 1'b1, 1'b1};
    prev = 8;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("sat_up_tc_%0d", k), 32'(s_tc), 32'(prev == 9));
      tick();
      chk($sformatf("sat_up_count_%0d", k), 32'(s_cnt), 32'(exp_sat[k]));
      chk($sformatf("sat_up_wrap_%0d", k),  32'(s_wp),  32'(exp_swp[k]));
      prev = exp_sat[k];
    end
    chk("sat_ovf", 32'(s_ovf), 32'd1);

    // ---------------- saturating: down from 1 ----------------
    s_en = 1'b0; s_load = 1'b1; s_lval = 4'd1;
    tick();
    s_load = 1'b0; s_en = 1'b1; s_up = 1'b0;
    tick();
    chk("sat_dn_count_0", 32'(s_cnt), 32'd0);
    chk("sat_dn_wrap_0",  32'(s_wp),  32'd0);
    chk("sat_dn_tc",      32'(s_tc),  32'd1);
    tick();
    chk("sat_dn_count_1", 32'(s_cnt), 32'd0);
    chk("sat_dn_wrap_1",  32'(s_wp),  32'd1);
    s_en = 1'b0;
    tick();
    chk("sat_idle_count", 32'(s_cnt), 32'd0);
    chk("sat_idle_wrap",  32'(s_wp),  32'd0);

`ifdef MOD_COUNTER_PRESCALE_EN
    // ---------------- prescale by 3 ----------------
    p_clr = 1'b1;
    tick();
    p_clr = 1'b0; p_en = 1'b1; p_up = 1'b1;
    begin
      int exp_p [6];
      exp_p = '{0, 0, 1, 1, 1, 2};
      for (int k = 0; k < 6; k++) begin
        tick();
        chk($sformatf("pre_count_%0d", k), 32'(p_cnt), 32'(exp_p[k]));
      end
    end
    tick();
    chk("pre_mid_count", 32'(p_cnt), 32'd2);
    p_clr = 1'b1;
    tick();
    chk("pre_clr_count", 32'(p_cnt), 32'd0);
    p_clr = 1'b0;
    tick();
    chk("pre_restart_0", 32'(p_cnt), 32'd0);
    tick();
    chk("pre_restart_1", 32'(p_cnt), 32'd0);
    tick();
    chk("pre_restart_2", 32'(p_cnt), 32'd1);
    p_load = 1'b1; p_lval = 4'd9;
    tick();
    p_load = 1'b0;
    chk("pre_load9", 32'(p_cnt), 32'd9);
    chk("pre_tc_0", 32'(p_tc), 32'd0);
    tick();
    chk("pre_tc_1", 32'(p_tc), 32'd0);
    tick();
    chk("pre_tc_2", 32'(p_tc), 32'd1);
    tick();
    chk("pre_wrap_count", 32'(p_cnt), 32'd0);
    chk("pre_wrap_pulse", 32'(p_wp),  32'd1);
    p_en = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
